cdc_fifo_wr_ctrl: RTL

- Write-side pointer and full-flag controller for an async FIFO, in the write clock domain.
- Feeds its Gray-coded write pointer into a 2-FF synchronizer toward the read domain.
- Consumes the read pointer after the return 2-FF synchronizer has brought it into this domain.
- Produces the RAM write address and strobe, plus full, almost-full, occupancy estimate and overflow flag.

---
 rtl/cdc_pkg.sv | 24 ++
 rtl/cdc_gray_cnt.sv | 44 ++++
 rtl/cdc_fifo_wr_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/cdc_pkg.sv
// Shared pointer helpers for the async FIFO write and read controllers.
// The functions work on a fixed wide vector; callers zero-extend and truncate to their own width.
package cdc_pkg;

    localparam int CDC_FN_W       = 32;
    localparam int CDC_ADDR_WIDTH = 4;

    typedef logic [CDC_ADDR_WIDTH:0] ptr_t;

    function automatic logic [CDC_FN_W-1:0] bin2gray(input logic [CDC_FN_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR from the MSB down recovers the binary value.
    function automatic logic [CDC_FN_W-1:0] gray2bin(input logic [CDC_FN_W-1:0] gray);
        logic [CDC_FN_W-1:0] bin;
        bin[CDC_FN_W-1] = gray[CDC_FN_W-1];
        for (int i = CDC_FN_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/cdc_gray_cnt.sv
// Binary/Gray pointer counter shared by both sides of the async FIFO.
// Both encodings are registered together, so the Gray output changes at most one bit per increment.
module cdc_gray_cnt
    import cdc_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] bin_o,
    output logic [WIDTH-1:0] gray_o,
    output logic [WIDTH-1:0] bin_next_o,
    output logic [WIDTH-1:0] gray_next_o
);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;

    // Next-pointer computation; wraps naturally modulo 2**WIDTH.
    always_comb begin
        w_bin_next  = r_bin + WIDTH'(inc_i);
        w_gray_next = WIDTH'(bin2gray(CDC_FN_W'(w_bin_next)));
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_gray <= '0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_gray_next;
        end
    end

    assign bin_o       = r_bin;
    assign gray_o      = r_gray;
    assign bin_next_o  = w_bin_next;
    assign gray_next_o = w_gray_next;

endmodule

// File: rtl/cdc_fifo_wr_ctrl.sv
// Write-domain pointer and status controller for an async FIFO.
// Status flags are computed from next pointers and registered; the read pointer never reaches an output combinationally.
module cdc_fifo_wr_ctrl
    import cdc_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 2**ADDR_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync_i,
    output logic                  wr_fire_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray_o,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic                  overflow_o
);

    localparam int PW = ADDR_WIDTH + 1;

    logic          w_fire;
    logic [PW-1:0] w_bin;
    logic [PW-1:0] w_gray;
    logic [PW-1:0] w_bin_next;
    logic [PW-1:0] w_gray_next;
    logic [PW-1:0] w_rd_bin;
    logic [PW-1:0] w_rd_full_cmp;
    logic [PW-1:0] w_level_next;
    logic          w_full_next;
    logic          w_af_next;
    logic          w_unused_bin_msb;

    logic          r_full;
    logic          r_af;
    logic [PW-1:0] r_level;
    logic          r_ovf;

    // Pushes during reset are dropped so nothing reaches the RAM before the pointers settle.
    assign w_fire = wr_en_i & ~r_full & ~rst;

    cdc_gray_cnt #(
        .WIDTH (PW)
    ) u_wr_cnt (
        .clk         (clk),
        .rst         (rst),
        .inc_i       (w_fire),
        .bin_o       (w_bin),
        .gray_o      (w_gray),
        .bin_next_o  (w_bin_next),
        .gray_next_o (w_gray_next)
    );

    // Full when the next write pointer equals the read pointer with its top two Gray bits inverted.
    always_comb begin
        w_rd_bin      = PW'(gray2bin(CDC_FN_W'(rd_ptr_gray_sync_i)));
        w_rd_full_cmp = {~rd_ptr_gray_sync_i[PW-1:PW-2], rd_ptr_gray_sync_i[PW-3:0]};
        w_full_next   = (w_gray_next == w_rd_full_cmp);
        w_level_next  = w_bin_next - w_rd_bin;
        w_af_next     = (w_level_next >= PW'(AF_THRESH));
    end

    // Registered status; overflow is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full  <= 1'b0;
            r_af    <= 1'b0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_full  <= w_full_next;
            r_af    <= w_af_next;
            r_level <= w_level_next;
            if (wr_en_i & r_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign w_unused_bin_msb = w_bin[PW-1];

    assign wr_fire_o     = w_fire;
    assign wr_addr_o     = w_bin[ADDR_WIDTH-1:0];
    assign wr_ptr_gray_o = w_gray;
    assign full_o        = r_full;
    assign almost_full_o = r_af;
    assign level_o       = r_level;
    assign overflow_o    = r_ovf;

endmodule
